// File: rtl/mem_stage.sv
// Memory-access pipeline stage. It waits for data-SRAM responses, aligns and extends load data,
// forwards results to ID and drops stale responses that belong to flushed requests.
module mem_stage #(
    parameter int PASS_W = 120
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_to_mem_valid,
    output logic                  mem_allowin,
    input  logic [76+PASS_W-1:0]  ex_to_mem_bus,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata,
    input  logic                  wb_allowin,
    output logic                  mem_to_wb_valid,
    output logic [70+PASS_W-1:0]  mem_to_wb_bus,
    output logic [38:0]           mem_to_id_bus,
    output logic                  mem_ex_hint,
    input  logic                  wb_flush
);
    // Once the named fields are packed, both bus widths leave PASS_W-2 bits of opaque sideband.
    localparam int SIDE_W = PASS_W - 2;

    typedef struct packed {
        logic [31:0]       pc;
        logic              rf_we;
        logic [4:0]        rf_waddr;
        logic [31:0]       alu_result;
        logic [4:0]        ld_op;      // one-hot {b, bu, h, hu, w}
        logic              mem_req;
        logic              excep_en;
        logic              ertn;
        logic [SIDE_W-1:0] pass;
    } ex_bus_t;

    typedef struct packed {
        logic              rf_we;
        logic [4:0]        rf_waddr;
        logic [31:0]       rf_wdata;
        logic [31:0]       pc;
        logic              excep_en;
        logic              ertn;
        logic [SIDE_W-1:0] pass;
    } wb_bus_t;

    ex_bus_t     w_ex;
    ex_bus_t     r_pl;
    wb_bus_t     w_wb;
    logic        r_mem_valid;
    logic        r_wait_data;
    logic [1:0]  r_discard_cnt;
    logic [31:0] r_hold_data;

    logic        w_resp_mine;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_kill_wait;
    logic        w_kill_enter;
    logic        w_stale;
    logic [2:0]  w_cnt_raw;
    logic [1:0]  w_cnt_next;
    logic [31:0] w_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rf_wdata;
    logic        w_fwd_we;
    logic        w_fwd_pending;

    assign w_ex = ex_bus_t'(ex_to_mem_bus);

    // A response is ours only once every stale response ahead of it has been swallowed.
    assign w_resp_mine     = r_wait_data & data_sram_data_ok & (r_discard_cnt == 2'd0);
    assign w_ready_go      = ~r_wait_data | w_resp_mine;
    assign mem_allowin     = ~r_mem_valid | (w_ready_go & wb_allowin);
    assign w_accept        = ex_to_mem_valid & mem_allowin & ~wb_flush;
    assign mem_to_wb_valid = r_mem_valid & w_ready_go & ~wb_flush;

    assign w_kill_wait  = wb_flush & r_wait_data & ~w_resp_mine;
    assign w_kill_enter = wb_flush & ex_to_mem_valid & mem_allowin & w_ex.mem_req;
    assign w_stale      = data_sram_data_ok & (r_discard_cnt != 2'd0);
    assign w_cnt_raw    = {1'b0, r_discard_cnt} + {2'b00, w_kill_wait}
                        + {2'b00, w_kill_enter} - {2'b00, w_stale};
    assign w_cnt_next   = (w_cnt_raw > 3'd3) ? 2'd3 : w_cnt_raw[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid   <= 1'b0;
            r_wait_data   <= 1'b0;
            r_discard_cnt <= 2'd0;
            // NOTE: the payload and hold data are reset as well so every output is defined right
            // after reset; this is a handful of flops, not a memory array.
            r_pl          <= '0;
            r_hold_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; where a signal is assigned twice below,
            // the later assignment wins, which is how accept overrides the hold-capture clear.
            r_discard_cnt <= w_cnt_next;
            if (wb_flush)
                r_mem_valid <= 1'b0;
            else if (mem_allowin)
                r_mem_valid <= ex_to_mem_valid;
            if (w_resp_mine) begin
                r_hold_data <= data_sram_rdata;
                r_wait_data <= 1'b0;
            end
            if (wb_flush)
                r_wait_data <= 1'b0;
            if (w_accept) begin
                r_pl        <= w_ex;
                r_wait_data <= w_ex.mem_req & ~w_ex.excep_en;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) w_cnt_raw <= 3'd3);

    // Live SRAM data while waiting; the hold register once the response has been taken.
    assign w_rdata = r_wait_data ? data_sram_rdata : r_hold_data;

    always_comb begin
        w_byte = w_rdata[7:0];
        case (r_pl.alu_result[1:0])
            2'd0: w_byte = w_rdata[7:0];
            2'd1: w_byte = w_rdata[15:8];
            2'd2: w_byte = w_rdata[23:16];
            2'd3: w_byte = w_rdata[31:24];
            default: w_byte = w_rdata[7:0];
        endcase
        w_half     = r_pl.alu_result[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_rf_wdata = r_pl.alu_result;
        if (r_pl.ld_op[4])
            w_rf_wdata = {{24{w_byte[7]}}, w_byte};
        else if (r_pl.ld_op[3])
            w_rf_wdata = {24'd0, w_byte};
        else if (r_pl.ld_op[2])
            w_rf_wdata = {{16{w_half[15]}}, w_half};
        else if (r_pl.ld_op[1])
            w_rf_wdata = {16'd0, w_half};
        else if (r_pl.ld_op[0])
            w_rf_wdata = w_rdata;
    end

    assign w_fwd_we      = r_mem_valid & r_pl.rf_we & ~r_pl.excep_en;
    assign w_fwd_pending = w_fwd_we & r_wait_data & (|r_pl.ld_op);
    assign mem_to_id_bus = w_fwd_we ? {1'b1, r_pl.rf_waddr, w_rf_wdata, w_fwd_pending} : 39'd0;
    assign mem_ex_hint   = r_mem_valid & (r_pl.excep_en | r_pl.ertn);

    assign w_wb.rf_we    = r_pl.rf_we & ~r_pl.excep_en;
    assign w_wb.rf_waddr = r_pl.rf_waddr;
    assign w_wb.rf_wdata = w_rf_wdata;
    assign w_wb.pc       = r_pl.pc;
    assign w_wb.excep_en = r_pl.excep_en;
    assign w_wb.ertn     = r_pl.ertn;
    assign w_wb.pass     = r_pl.pass;
    assign mem_to_wb_bus = w_wb;
endmodule
